// File: rtl/nrs_re_mapper_tx.sv
// NRS resource-element mapper: walks the 16 NRS positions of one NB-IoT PRB per
// subframe, reads the generator combinationally and issues one registered grid write per position.
module nrs_re_mapper_tx #(
    parameter int WIDTH_REG = 16,
    parameter int WIDTH_B   = 9,
    parameter int LINES     = $clog2(WIDTH_REG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sf_start,
    input  logic [WIDTH_B-1:0]   N_cell_ID,
    input  logic [WIDTH_REG-1:0] nrs_mapper_1r,
    input  logic [WIDTH_REG-1:0] nrs_mapper_1i,
    input  logic [WIDTH_REG-1:0] nrs_mapper_2r,
    input  logic [WIDTH_REG-1:0] nrs_mapper_2i,
    output logic [LINES-1:0]     rd_addr_mapper_1r,
    output logic [LINES-1:0]     rd_addr_mapper_1i,
    output logic [LINES-1:0]     rd_addr_mapper_2r,
    output logic [LINES-1:0]     rd_addr_mapper_2i,
    output logic                 wr_en,
    output logic                 wr_port,
    output logic [3:0]           wr_sym,
    output logic [3:0]           wr_sc,
    output logic [WIDTH_REG-1:0] wr_re,
    output logic [WIDTH_REG-1:0] wr_im,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2:0]           vshift_q, vshift_d;
    logic                 wr_en_q, wr_en_d;
    logic                 wr_port_q, wr_port_d;
    logic [3:0]           wr_sym_q, wr_sym_d;
    logic [3:0]           wr_sc_q, wr_sc_d;
    logic [WIDTH_REG-1:0] wr_re_q, wr_re_d;
    logic [WIDTH_REG-1:0] wr_im_q, wr_im_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    // Position fields decoded from the walk counter.
    logic                 slot, sym_sel, m, port;
    logic [WIDTH_B-1:0]   cid_mod6;
    logic [2:0]           v;
    logic [3:0]           sc_sum, sc_mod;
    logic [LINES-1:0]     addr_even;

    assign slot     = cnt_q[3];
    assign sym_sel  = cnt_q[2];
    assign m        = cnt_q[1];
    assign port     = cnt_q[0];
    assign cid_mod6 = N_cell_ID % WIDTH_B'(6);
    assign v        = (port ^ sym_sel) ? 3'd3 : 3'd0;
    assign sc_sum   = 4'(v) + 4'(vshift_q);
    assign sc_mod   = (sc_sum >= 4'd6) ? sc_sum - 4'd6 : sc_sum;

    assign addr_even         = (state_q == RUN) ? LINES'({cnt_q[3:1], 1'b0}) : '0;
    assign rd_addr_mapper_1r = addr_even;
    assign rd_addr_mapper_2r = addr_even;
    assign rd_addr_mapper_1i = (state_q == RUN) ? LINES'({cnt_q[3:1], 1'b1}) : '0;
    assign rd_addr_mapper_2i = rd_addr_mapper_1i;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        vshift_d  = vshift_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        wr_port_d = wr_port_q;
        wr_sym_d  = wr_sym_q;
        wr_sc_d   = wr_sc_q;
        wr_re_d   = wr_re_q;
        wr_im_d   = wr_im_q;

        case (state_q)
            IDLE: begin
                if (sf_start) begin
                    state_d  = RUN;
                    cnt_d    = 4'd0;
                    vshift_d = cid_mod6[2:0];
                end
            end
            RUN: begin
                wr_en_d   = 1'b1;
                wr_port_d = port;
                wr_sym_d  = (slot ? 4'd12 : 4'd5) + 4'(sym_sel);
                wr_sc_d   = m ? sc_mod + 4'd6 : sc_mod;
                wr_re_d   = port ? nrs_mapper_2r : nrs_mapper_1r;
                wr_im_d   = port ? nrs_mapper_2i : nrs_mapper_1i;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FLUSH;
                    done_d  = 1'b1;
                end
                if (sf_start) overrun_d = 1'b1;
            end
            FLUSH: begin
                // A start on the FLUSH exit edge is accepted so runs can repeat every 17 cycles.
                state_d = IDLE;
                if (sf_start) begin
                    state_d  = RUN;
                    cnt_d    = 4'd0;
                    vshift_d = cid_mod6[2:0];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            vshift_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_port_q <= 1'b0;
            wr_sym_q  <= '0;
            wr_sc_q   <= '0;
            wr_re_q   <= '0;
            wr_im_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vshift_q  <= vshift_d;
            wr_en_q   <= wr_en_d;
            wr_port_q <= wr_port_d;
            wr_sym_q  <= wr_sym_d;
            wr_sc_q   <= wr_sc_d;
            wr_re_q   <= wr_re_d;
            wr_im_q   <= wr_im_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_port = wr_port_q;
    assign wr_sym  = wr_sym_q;
    assign wr_sc   = wr_sc_q;
    assign wr_re   = wr_re_q;
    assign wr_im   = wr_im_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule
